uart_rx_rd_arb: RTL and testbench
=================================

// Module: uart_rx_rd_arb
// PURPOSE
//  Shares the single read port of the UART RX async FIFO (read-side controller) among NREQ requesters.
//  Round-robin arbitration; one read in flight at a time. Pulses the FIFO read command, waits for the
//  FIFO's registered valid, then returns data to the granted requester. A watchdog aborts reads the
//  FIFO drops (FIFO went empty), so the port can never hang.
// PARAMETERS
//  NREQ     2   number of requesters (>=2)
//  DW       8   FIFO data width
//  TIMEOUT  4   WAIT-state cycles before abort (>=3)
// PORTS
//  clk           in   1        clock (FIFO read-side clock domain)
//  rst           in   1        asynchronous reset, active-high
//  req_i         in   NREQ     level request per requester; held until its rvalid_o bit pulses
//  gnt_o         out  NREQ     one-hot grant, held ISSUE..RESP
//  rvalid_o      out  NREQ     one-hot, 1-cycle response strobe
//  rdata_o       out  DW       read data, valid with rvalid_o
//  rerr_o        out  1        with rvalid_o: 1 = aborted read, rdata_o = 0
//  fifo_empty_i  in   1        FIFO empty flag
//  fifo_renc_o   out  1        FIFO read command, 1-cycle pulse
//  fifo_valid_i  in   1        FIFO read-data valid (2 cycles after renc when not empty)
//  fifo_rdata_i  in   DW       FIFO read data, sampled when fifo_valid_i=1
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rr_ptr=0, wdog=0; gnt_o, rvalid_o, rdata_o, rerr_o, fifo_renc_o = 0.
//  All outputs are registered. FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if |req_i && !fifo_empty_i, select winner: first asserted index scanning from rr_ptr upward,
//    wrapping at NREQ-1 -> 0; latch it into gnt_o; next state ISSUE. Otherwise stay; no grant while empty.
//  ISSUE: fifo_renc_o=1 (exactly one cycle per transaction); wdog cleared; -> WAIT.
//  WAIT: fifo_renc_o=0; wdog increments each cycle.
//    fifo_valid_i=1 -> capture fifo_rdata_i, rerr=0, -> RESP.
//    else wdog==TIMEOUT-1 -> rdata=0, rerr=1, -> RESP (read dropped by FIFO).
//    valid and timeout in the same cycle: valid wins.
//  RESP: rvalid_o = gnt_o for one cycle with rdata_o/rerr_o; rr_ptr = winner+1 (wrap to 0 at NREQ);
//    gnt_o cleared on exit; -> IDLE. rdata_o holds its value until the next RESP.
//  Latency: req_i sampled at cycle 0 (IDLE) -> fifo_renc_o cycle 1 -> fifo_valid_i cycle 3 -> rvalid_o cycle 4.
//    Max throughput: one read per 5 cycles. Abort path: rvalid_o at cycle TIMEOUT+2.
//  A single outstanding read is required: the FIFO empty flag lags the read pointer by one cycle,
//    so back-to-back commands could over-read.
//  fifo_valid_i outside WAIT is ignored (e.g. a read in flight across reset).
//  req_i dropped mid-transaction: transaction completes, rvalid_o still pulses; rr_ptr still advances.
//  fifo_empty_i rising after ISSUE does not cancel the transaction; the watchdog resolves it.
//  wdog width: $clog2(TIMEOUT+1); no wrap possible.
// TESTING
//  1. Reset; req_i=01, empty=0, FIFO returns 0xA5 -> renc at cycle 1 only; rvalid_o=01, rdata=0xA5,
//     rerr=0 at cycle 4.
//  2. req_i=11 held, 4 entries 0x10..0x13 -> grants 01,10,01,10; data 0x10..0x13 in order; 5-cycle spacing.
//  3. req_i=01 with empty=1 for 10 cycles -> gnt_o=0, fifo_renc_o=0; empty->0 -> normal read follows.
//  4. Model drops the read (no fifo_valid_i), TIMEOUT=4 -> rvalid_o=01, rerr=1, rdata=0 at cycle 6; then IDLE.
//  5. Assert rst in WAIT, FIFO valid arrives 1 cycle after release -> all outputs 0, no rvalid_o, rr_ptr=0.
//  6. Spurious fifo_valid_i in IDLE with req_i=0 -> no rvalid_o; rdata_o unchanged.

Source files
------------

// File: rtl/uart_rx_rd_arb.sv
// Round-robin arbiter for the UART RX async-FIFO read port: one read in flight,
// with a watchdog that aborts reads the FIFO silently drops.
module uart_rx_rd_arb #(
  parameter int NREQ    = 2,
  parameter int DW      = 8,
  parameter int TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            rerr_o,
  input  logic            fifo_empty_i,
  output logic            fifo_renc_o,
  input  logic            fifo_valid_i,
  input  logic [DW-1:0]   fifo_rdata_i
);

  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  sel_idx;
  logic [NREQ-1:0] sel_oh;
  logic [WW-1:0]  wdog;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] p);
    if (p == PW'(NREQ - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Scan downward so the asserted index closest to rr_ptr is the last one written.
  always_comb begin
    int idx;
    idx     = 0;
    sel_oh  = '0;
    sel_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_i[idx]) begin
        sel_oh      = '0;
        sel_oh[idx] = 1'b1;
        sel_idx     = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      win_idx     <= '0;
      wdog        <= '0;
      gnt_o       <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
      rerr_o      <= 1'b0;
      fifo_renc_o <= 1'b0;
    end else begin
      rvalid_o    <= '0;
      rerr_o      <= 1'b0;
      fifo_renc_o <= 1'b0;
      case (state)
        IDLE: begin
          // The empty flag lags the read pointer, so only one command may be outstanding.
          if (|req_i && !fifo_empty_i) begin
            gnt_o       <= sel_oh;
            win_idx     <= sel_idx;
            fifo_renc_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + WW'(1);
          if (fifo_valid_i) begin
            rdata_o  <= fifo_rdata_i;
            rvalid_o <= gnt_o;
            state    <= RESP;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            rdata_o  <= '0;
            rerr_o   <= 1'b1;
            rvalid_o <= gnt_o;
            state    <= RESP;
          end
        end
        RESP: begin
          gnt_o  <= '0;
          rr_ptr <= inc_wrap(win_idx);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_rd_arb.sv
// Directed bench for uart_rx_rd_arb with a small two-cycle-latency FIFO read model.
module tb_uart_rx_rd_arb;

  localparam int NREQ = 2;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_i = '0;
  logic [NREQ-1:0] gnt_o;
  logic [NREQ-1:0] rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            rerr_o;
  logic            fifo_empty_i;
  logic            fifo_renc_o;
  logic            fifo_valid_i;
  logic [DW-1:0]   fifo_rdata_i;

  // FIFO model state
  logic [DW-1:0] q[$];
  logic          drop = 1'b0;
  logic          force_empty = 1'b0;
  logic          s1 = 1'b0;
  logic [DW-1:0] sd = '0;
  logic          mv = 1'b0;
  logic [DW-1:0] md = '0;
  logic          inj_valid = 1'b0;
  logic [DW-1:0] inj_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_rd_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .rerr_o       (rerr_o),
    .fifo_empty_i (fifo_empty_i),
    .fifo_renc_o  (fifo_renc_o),
    .fifo_valid_i (fifo_valid_i),
    .fifo_rdata_i (fifo_rdata_i)
  );

  always #5 clk = ~clk;

  assign fifo_empty_i = force_empty | (q.size() == 0);
  assign fifo_valid_i = mv | inj_valid;
  assign fifo_rdata_i = inj_valid ? inj_data : md;

  always @(posedge clk) begin
    mv <= s1;
    md <= sd;
    s1 <= 1'b0;
    if (fifo_renc_o && q.size() > 0) begin
      if (!drop) s1 <= 1'b1;
      sd <= q.pop_front();
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rerr", rerr_o, 0);
    chk("rst_renc", fifo_renc_o, 0);
    rst = 1'b0;
    tick();

    // 1: single read of 0xA5 from requester 0
    q.push_back(8'hA5);
    req_i = 2'b01;
    tick();
    chk("t1_renc_c1", fifo_renc_o, 1);
    chk("t1_gnt_c1", gnt_o, 2'b01);
    tick();
    chk("t1_renc_c2", fifo_renc_o, 0);
    tick();
    chk("t1_rvalid_c3", rvalid_o, 0);
    tick();
    chk("t1_rvalid_c4", rvalid_o, 2'b01);
    chk("t1_rdata_c4", rdata_o, 8'hA5);
    chk("t1_rerr_c4", rerr_o, 0);
    req_i = 2'b00;
    tick();
    chk("t1_rvalid_c5", rvalid_o, 0);
    chk("t1_gnt_c5", gnt_o, 0);

    // 2: both requesting, four entries, alternating grants at 5-cycle spacing
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'h10 + 8'(i));
    req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t2_renc", fifo_renc_o, 1);
      chk("t2_gnt", gnt_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick(3);
      chk("t2_rvalid", rvalid_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_rdata", rdata_o, 8'h10 + 8'(t));
      chk("t2_rerr", rerr_o, 0);
      if (t == 3) req_i = 2'b00;
      tick();
    end

    // 3: no grant while the FIFO reports empty
    q.push_back(8'h3C);
    force_empty = 1'b1;
    req_i = 2'b01;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t3_gnt_empty", gnt_o, 0);
      chk("t3_renc_empty", fifo_renc_o, 0);
    end
    force_empty = 1'b0;
    tick();
    chk("t3_renc", fifo_renc_o, 1);
    chk("t3_gnt", gnt_o, 2'b01);
    tick(3);
    chk("t3_rvalid", rvalid_o, 2'b01);
    chk("t3_rdata", rdata_o, 8'h3C);
    req_i = 2'b00;
    tick();

    // 4: FIFO drops the read, watchdog aborts at cycle 6
    drop = 1'b1;
    q.push_back(8'h55);
    req_i = 2'b01;
    tick();
    chk("t4_renc", fifo_renc_o, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("t4_rvalid_wait", rvalid_o, 0);
    end
    tick();
    chk("t4_rvalid_c6", rvalid_o, 2'b01);
    chk("t4_rerr_c6", rerr_o, 1);
    chk("t4_rdata_c6", rdata_o, 0);
    req_i = 2'b00;
    tick();
    chk("t4_rvalid_c7", rvalid_o, 0);
    chk("t4_rerr_c7", rerr_o, 0);
    chk("t4_gnt_c7", gnt_o, 0);

    // 5: reset during WAIT, late FIFO valid after release is ignored
    q.push_back(8'h77);
    req_i = 2'b01;
    tick();
    chk("t5_renc", fifo_renc_o, 1);
    tick();
    rst = 1'b1;
    req_i = 2'b00;
    #1;
    chk("t5_async_gnt", gnt_o, 0);
    chk("t5_async_renc", fifo_renc_o, 0);
    tick();
    rst = 1'b0;
    tick();
    inj_valid = 1'b1;
    inj_data = 8'h99;
    tick();
    inj_valid = 1'b0;
    chk("t5_rvalid", rvalid_o, 0);
    chk("t5_rdata", rdata_o, 0);
    chk("t5_rerr", rerr_o, 0);
    chk("t5_gnt", gnt_o, 0);
    tick();
    chk("t5_rvalid2", rvalid_o, 0);
    drop = 1'b0;
    q.push_back(8'h21);
    req_i = 2'b11;
    tick();
    chk("t5_rrptr_gnt", gnt_o, 2'b01);
    tick(3);
    chk("t5_post_rvalid", rvalid_o, 2'b01);
    chk("t5_post_rdata", rdata_o, 8'h21);
    req_i = 2'b00;
    tick();

    // 6: spurious FIFO valid in IDLE
    inj_valid = 1'b1;
    inj_data = 8'hEE;
    tick();
    inj_valid = 1'b0;
    chk("t6_rvalid", rvalid_o, 0);
    chk("t6_rdata", rdata_o, 8'h21);
    tick();
    chk("t6_rvalid2", rvalid_o, 0);
    chk("t6_rdata2", rdata_o, 8'h21);
    chk("t6_gnt", gnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
